// File: rtl/uart_pkg.sv
// Shared UART types, baud table and helpers for the TX and RX paths.
package uart_pkg;

    // Widest payload any UART frame in this codebase carries.
    localparam int unsigned MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        StopOne     = 2'b00,
        StopOneHalf = 2'b01,
        StopTwo     = 2'b10,
        StopTwoAlt  = 2'b11
    } uart_stop_t;

    // Baud rate per br code; unused codes fall back to 115200.
    localparam int unsigned BAUD_TABLE [16] = '{
        1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200,
        230400, 460800, 115200, 115200, 115200, 115200, 115200, 115200
    };

    // Clock cycles per bit, floored; never zero so a bit always lasts one cycle.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [3:0] br);
        int unsigned div;
        div = clk_freq / BAUD_TABLE[br];
        if (div == 0) begin
            div = 1;
        end
        return div;
    endfunction

    // Even parity when odd=0, odd parity when odd=1; unused upper bits must be zero.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the UART TX and RX paths.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the count alone, so a same-cycle pop never frees room for a push.
    assign full    = (level_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally at the power-of-two depth; level tracks net push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end plus a serializer that drains it
// back-to-back. Line settings are captured per frame when a word is popped.
// Optional feature macro UART_TX_BREAK_EN adds a brk input that forces a line
// break between frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef UART_TX_BREAK_EN
    input  logic                        brk,
`endif
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        signal_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic [3:0]                  br,
    input  logic [1:0]                  sbl,
    input  logic                        parity_on,
    input  logic                        parity_set,
    input  logic                        seniority_h
);

    // Slowest baud sets the counter width; two stop bits need twice that.
    localparam int unsigned MAX_DIV = baud_div(CLK_FREQ, 4'd0);
    localparam int unsigned CNT_W   = $clog2(2 * MAX_DIV + 1);
    localparam int unsigned IDX_W   = $clog2(DATA_WIDTH);

    uart_tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        div_q, div_d;
    logic [CNT_W-1:0]        stop_q, stop_d;
    logic                    par_on_q, par_on_d;
    logic                    par_odd_q, par_odd_d;
    logic                    msb_q, msb_d;
    logic                    tx_q, tx_d;

    logic                    pop;
    logic                    load_frame;
    logic                    full;
    logic                    empty;
    logic [DATA_WIDTH-1:0]   head;
    logic [CNT_W-1:0]        div_lut [16];
    logic [CNT_W-1:0]        nf_div;
    logic [CNT_W-1:0]        nf_stop;
    logic                    brk_active;

`ifdef UART_TX_BREAK_EN
    assign brk_active = brk;
`else
    assign brk_active = 1'b0;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Divisors are elaboration-time constants, so the runtime select is a small mux.
    for (genvar i = 0; i < 16; i++) begin : g_div_lut
        assign div_lut[i] = CNT_W'(baud_div(CLK_FREQ, 4'(i)));
    end

    // Bit timing for the frame that would start now, from the live tuner inputs.
    always_comb begin
        nf_div = div_lut[br];
        case (uart_stop_t'(sbl))
            StopOne:     nf_stop = nf_div;
            StopOneHalf: nf_stop = nf_div + (nf_div >> 1);
            default:     nf_stop = nf_div + nf_div;
        endcase
    end

    // Data bit at position i of the frame, honouring the latched bit order.
    function automatic logic sel_bit(input logic [DATA_WIDTH-1:0] d, input logic [IDX_W-1:0] i,
                                     input logic msb);
        logic [IDX_W-1:0] j;
        j = msb ? (IDX_W'(DATA_WIDTH - 1) - i) : i;
        return d[j];
    endfunction

    // Serializer next state; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        div_d      = div_q;
        stop_d     = stop_q;
        par_on_d   = par_on_q;
        par_odd_d  = par_odd_q;
        msb_d      = msb_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        load_frame = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (brk_active) begin
                    tx_d = 1'b0;
                end else if (!empty) begin
                    load_frame = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    idx_d   = IDX_W'(0);
                    cnt_d   = div_q - 1'b1;
                    tx_d    = sel_bit(data_q, IDX_W'(0), msb_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q - 1'b1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        if (par_on_q) begin
                            state_d = StParity;
                            tx_d    = parity_bit(MAX_DATA_WIDTH'(data_q), par_odd_q);
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                            cnt_d   = stop_q - 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = sel_bit(data_q, idx_q + 1'b1, msb_q);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StParity: begin
                if (cnt_q == '0) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    cnt_d   = stop_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next start bit; a pending break waits in idle.
                    if (!brk_active && !empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Pop the head word and freeze the line settings for the whole frame.
        if (load_frame) begin
            pop       = 1'b1;
            state_d   = StStart;
            tx_d      = 1'b0;
            cnt_d     = nf_div - 1'b1;
            idx_d     = IDX_W'(0);
            data_d    = head;
            div_d     = nf_div;
            stop_d    = nf_stop;
            par_on_d  = parity_on;
            par_odd_d = parity_set;
            msb_d     = seniority_h;
        end
    end

    // Serializer state and registered line output; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            div_q     <= '0;
            stop_q    <= '0;
            par_on_q  <= 1'b0;
            par_odd_q <= 1'b0;
            msb_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            div_q     <= div_d;
            stop_q    <= stop_d;
            par_on_q  <= par_on_d;
            par_odd_q <= par_odd_d;
            msb_q     <= msb_d;
            tx_q      <= tx_d;
        end
    end

    assign signal_tx = tx_q;
    assign s_ready   = !full;
    assign busy      = (state_q != StIdle) || !empty;

endmodule
